// File: rtl/cnt3_pkg.sv
// Shared types and constants for the base-3 counter sequencer.
// Digit width/limit and controller state encoding.
package cnt3_pkg;

  localparam int         DIGIT_W   = 2;
  localparam logic [1:0] DIGIT_MAX = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSE  = 2'd2,
    S_REWIND = 2'd3
  } state_e;

  function automatic logic dig_bad(
    input logic [DIGIT_W-1:0] d
  );
    return d > DIGIT_MAX;
  endfunction

endpackage

// File: rtl/cnt3_seq_ctrl_if.sv
// Command/status and counter-feedback bundle of the sequencer.
// master drives commands and counter digits; slave is the controller.
interface cnt3_seq_ctrl_if
  import cnt3_pkg::*;
#(
  parameter int PRE_W = 4
);
  logic               start;
  logic               stop;
  logic               rewind;
  logic               one_shot;
  logic [PRE_W-1:0]   period;
  logic [DIGIT_W-1:0] target_hi;
  logic [DIGIT_W-1:0] target_lo;
  logic [DIGIT_W-1:0] cnt_hi;
  logic [DIGIT_W-1:0] cnt_lo;
  logic               up;
  logic               busy;
  logic               done;
  logic               err;
  logic [1:0]         state_o;

  modport master (
    output start, stop, rewind, one_shot,
    output period, target_hi, target_lo,
    output cnt_hi, cnt_lo,
    input  up, busy, done, err, state_o
  );

  modport slave (
    input  start, stop, rewind, one_shot,
    input  period, target_hi, target_lo,
    input  cnt_hi, cnt_lo,
    output up, busy, done, err, state_o
  );

endinterface

// File: rtl/cnt3_prescaler.sv
// Loadable down-counter setting the step rate.
// Reloads on zero while enabled; holds its value when disabled.
module cnt3_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  assign o_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en) begin
      r_cnt <= o_zero ? i_val : r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cnt3_seq_ctrl.sv
// Sequencer driving the base-3 counter's up strobe.
// Runs to a latched target, pauses, and rewinds via wrap-around.
module cnt3_seq_ctrl
  import cnt3_pkg::*;
#(
  parameter int PRE_W = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  cnt3_seq_ctrl_if.slave bus
);

  state_e r_state;
  state_e w_next;

  logic [PRE_W-1:0]   r_per_q;
  logic [DIGIT_W-1:0] r_thi_q;
  logic [DIGIT_W-1:0] r_tlo_q;
  logic               r_one_q;
  logic               r_stepped;
  logic               r_done;
  logic               r_err;

  logic               w_up;
  logic               w_err_d;
  logic               w_bad;
  logic               w_go;
  logic               w_match;
  logic               w_cnt_zero;
  logic               w_psc_zero;
  logic [PRE_W-1:0]   w_per_in;
  logic [PRE_W-1:0]   w_psc_val;

  function automatic logic [PRE_W-1:0] max1(
    input logic [PRE_W-1:0] p
  );
    return (p == '0) ? PRE_W'(1) : p;
  endfunction

  assign w_cnt_zero = (bus.cnt_hi == '0)
                   && (bus.cnt_lo == '0);
  assign w_bad = dig_bad(bus.target_hi)
              || dig_bad(bus.target_lo);
  assign w_go = (r_state == S_IDLE)
             && bus.start && !w_bad;
  assign w_per_in  = max1(bus.period);
  assign w_psc_val = w_go ? w_per_in : r_per_q;

  // Only a count reached by a step while running can match.
  assign w_match = (r_state == S_RUN) && r_stepped
                && (bus.cnt_hi == r_thi_q)
                && (bus.cnt_lo == r_tlo_q);

  cnt3_prescaler #(
    .W (PRE_W)
  ) u_psc (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_load (w_go),
    .i_en   (r_state == S_RUN),
    .i_val  (w_psc_val),
    .o_zero (w_psc_zero)
  );

  always_comb begin
    w_up = 1'b0;
    unique case (1'b1)
      (r_state == S_RUN):    w_up = w_psc_zero;
      (r_state == S_REWIND): w_up = !w_cnt_zero;
      default:               w_up = 1'b0;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_err_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_bad) w_err_d = 1'b1;
          else       w_next  = S_RUN;
        end else if (bus.rewind) begin
          w_next = S_REWIND;
        end
      end
      S_RUN: begin
        if (bus.stop)                w_next = S_PAUSE;
        else if (w_match && r_one_q) w_next = S_IDLE;
      end
      S_PAUSE: begin
        if (bus.stop)        w_next = S_IDLE;
        else if (bus.rewind) w_next = S_REWIND;
        else if (bus.start)  w_next = S_RUN;
      end
      S_REWIND: begin
        if (w_cnt_zero) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_stepped <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_stepped <= w_up;
      r_done    <= w_match;
      r_err     <= w_err_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_per_q <= '0;
      r_thi_q <= '0;
      r_tlo_q <= '0;
      r_one_q <= 1'b0;
    end else if (w_go) begin
      r_per_q <= w_per_in;
      r_thi_q <= bus.target_hi;
      r_tlo_q <= bus.target_lo;
      r_one_q <= bus.one_shot;
    end
  end

  assign bus.up      = w_up;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.state_o = r_state;

endmodule

// File: doc/cnt3_seq_ctrl.md
Name: cnt3_seq_ctrl

Overview:
- Sequencer for the team's two-digit base-3 up counter (digits 0..2, value range 00..22, inputs clk/n_rst/up, outputs units/tens).
- Generates the counter's `up` strobe at a programmable rate and stops or flags when the counter reaches a latched target.
- Supports pause/resume, and rewinds the counter to 00 by stepping it through wrap-around, since the counter has no synchronous clear.
- Sits between the command/register interface and the counter instance.

Parameters:
PRE_W, 4, width of prescaler period field; step interval is max(period,1)+1 cycles.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: begin run from IDLE, or resume from PAUSE
- stop  in  1  pulse: pause in RUN; abort to IDLE from PAUSE
- rewind  in  1  pulse: return counter to 00; honoured in IDLE/PAUSE only
- one_shot  in  1  1 = halt on target match; 0 = free-run, done on every match; latched at start
- period  in  PRE_W  step interval control; latched at start
- target_hi  in  2  tens digit target; latched at start
- target_lo  in  2  units digit target; latched at start
- cnt_hi  in  2  counter tens digit (observed)
- cnt_lo  in  2  counter units digit (observed)
- up  out  1  step strobe to counter (combinational from state/prescaler/cnt inputs)
- busy  out  1  1 in RUN, PAUSE, REWIND
- done  out  1  registered 1-cycle pulse on target reached
- err  out  1  registered 1-cycle pulse on rejected start
- state_o  out  2  current state encoding, debug

Behaviour:
- Reset: state=IDLE, prescaler=0, stepped=0, latched regs=0, done=0, err=0, up=0, busy=0.
- States: IDLE=0, RUN=1, PAUSE=2, REWIND=3.
- IDLE:
  - start with target_hi==3 or target_lo==3 -> err=1 next cycle, stay IDLE.
  - Valid start -> latch period/target/one_shot, prescaler=max(period,1), go RUN.
  - rewind -> REWIND.
  - start and rewind together -> start wins.
- RUN:
  - Prescaler decrements each cycle.
  - up=1 in the cycle prescaler==0; prescaler reloads max(period,1) at the same edge.
  - Steps therefore occur every max(period,1)+1 cycles; period 0 and 1 are identical.
- stepped: register = previous-cycle up.
- Match: in a cycle with stepped==1 and {cnt_hi,cnt_lo}=={target_hi_q,target_lo_q}:
  - done=1 the next cycle.
  - If one_shot_q, state -> IDLE at the same edge.
  - Counter already at target when start is accepted does not match; only a value reached by a step counts.
- Counter wrap: 22 -> 00 needs no special handling by the controller. In free-run, done fires once per 9 steps.
- stop in RUN -> PAUSE: prescaler frozen, up=0. stop has priority over start and over a same-cycle match transition. done still pulses if the match condition held that cycle.
- PAUSE:
  - start -> RUN, prescaler resumes from its frozen value; latched regs unchanged.
  - stop -> IDLE.
  - rewind -> REWIND.
  - Priority when inputs collide: stop > rewind > start.
- REWIND:
  - up = (cnt != 00), stepping every cycle.
  - In the first cycle cnt==00 is observed -> IDLE; no done.
  - Maximum 8 up cycles (from 01).
  - Counter already at 00 -> IDLE after 1 cycle, up never asserted.
  - start/stop ignored.
- rewind in RUN: ignored.
- Commands are sampled every cycle; held levels act as repeated pulses.
- Async reset mid-operation: all regs return to reset values immediately; up drops to 0 combinationally.

Decomposition:
- Shared package cnt3_pkg: state enum (IDLE/RUN/PAUSE/REWIND), DIGIT_MAX=2'd2, DIGIT_W=2.
- One natural sub-module: cnt3_prescaler (load/enable/frozen down-counter, zero flag).
- Bench instantiates the real base-3 counter driven by up and fed back on cnt_hi/cnt_lo.

Test Plan:
1. Reset, counter 00; period=0, target=1/2, one_shot=1, start. Expect up on cycles 2,4,6,8,10 after start; cnt reaches 12; done one cycle later; state IDLE; 5 up pulses total.
2. period=3, target=0/1, one_shot=0, start, run 60 cycles. Expect up every 4th cycle; done at counts 01 only, every 36 cycles; wrap 22->00 without glitch.
3. Run to cnt=11, stop. Expect up held 0 for 10 cycles and prescaler frozen. Then start: next up exactly after remaining prescaler count. Stop+start in the same cycle -> PAUSE.
4. From PAUSE with cnt=01, rewind. Expect 8 consecutive up cycles (through 22->00), then IDLE, busy=0, no done. Rewind at 00 -> 1 cycle, no up.
5. start with target_lo=3. Expect err pulse, state stays IDLE, up never asserted.
6. Assert n_rst low mid-RUN with up=1. Expect up=0, busy=0, state_o=0 immediately. After release, no up until a new start.
